// File: rtl/event_sequencer.sv
// event_sequencer: replays a host-loaded table of timestamped trigger events against a free-running
// timestamp counter; defining EVSEQ_STATS_EN adds saturating l1a_cnt/late_cnt statistics outputs.
module event_sequencer #(
    parameter int NLCT  = 8,
    parameter int TS_W  = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            start,
    input  logic            stop,
    input  logic            loop,
    input  logic [AW:0]     num_ev,
    input  logic            ld_we,
    input  logic [AW-1:0]   ld_addr,
    input  logic [TS_W-1:0] ld_ts,
    input  logic [2:0]      ld_flags,
    input  logic [NLCT-1:0] ld_lct,
    output logic            l1a,
    output logic            alct_dav,
    output logic            otmb_dav,
    output logic [NLCT-1:0] lct,
    output logic [TS_W-1:0] ts_cnt,
    output logic            busy,
    output logic            done,
    output logic            err_late
`ifdef EVSEQ_STATS_EN
    ,
    output logic [15:0]     l1a_cnt,
    output logic [15:0]     late_cnt
`endif
);
    localparam int EW = TS_W + 3 + NLCT;

    typedef enum logic [2:0] {IDLE, PF0, PF1, RUN, FIN} state_t;

    state_t state, state_d;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] rd_data, cur, nxt;
    logic [AW-1:0] rd_ptr, rd_ptr_d, cur_idx;
    logic [AW:0] num_r;
    logic [TS_W-1:0] cur_ts;
    logic go, run_en, hit, late, consume, last;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] i, input logic [AW:0] n);
        return ({1'b0, i} == n - 1'b1) ? '0 : i + 1'b1;
    endfunction

    assign cur_ts  = cur[EW-1 -: TS_W];
    assign busy    = (state == PF0) || (state == PF1) || (state == RUN);
    assign go      = (state == IDLE) && start;
    assign run_en  = (state == RUN) && en && !stop;
    assign hit     = run_en && (cur_ts == ts_cnt);
    assign late    = run_en && (cur_ts < ts_cnt);
    assign consume = hit || late;
    assign last    = ({1'b0, cur_idx} == num_r - 1'b1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next state and the table read pointer; rd_data always holds the entry after nxt
    always_comb begin
        state_d  = state;
        rd_ptr_d = rd_ptr;
        case (state)
            IDLE: begin
                state_d  = (go && num_ev != '0) ? PF0 : IDLE;
                rd_ptr_d = go ? '0 : rd_ptr;
            end
            PF0, PF1: begin
                state_d  = stop ? IDLE : (state == PF0 ? PF1 : RUN);
                rd_ptr_d = wrap_inc(rd_ptr, num_r);
            end
            RUN: begin
                state_d  = stop ? IDLE : ((consume && last && !loop) ? FIN : RUN);
                rd_ptr_d = consume ? wrap_inc(rd_ptr, num_r) : rd_ptr;
            end
            default: state_d = IDLE;
        endcase
    end

    // Event pipeline, timestamp counter, registered fire outputs and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {l1a, alct_dav, otmb_dav} <= 3'b0;
            lct      <= '0;
            ts_cnt   <= '0;
            done     <= 1'b0;
            err_late <= 1'b0;
            rd_ptr   <= '0;
            cur_idx  <= '0;
            num_r    <= '0;
            cur      <= '0;
            nxt      <= '0;
        end else begin
            rd_ptr   <= rd_ptr_d;
            done     <= (state == FIN) || (go && num_ev == '0);
            {l1a, alct_dav, otmb_dav} <= hit ? cur[NLCT +: 3] : 3'b0;
            lct      <= hit ? cur[NLCT-1:0] : '0;
            err_late <= go ? 1'b0 : (err_late || late);
            if (go) num_r <= num_ev;
            if (state == PF0) begin
                cur     <= rd_data;
                cur_idx <= '0;
            end
            if (state == PF1) begin
                nxt    <= rd_data;
                ts_cnt <= '0;
            end
            if (consume) begin
                cur     <= nxt;
                nxt     <= rd_data;
                cur_idx <= wrap_inc(cur_idx, num_r);
            end
            if (run_en) ts_cnt <= (consume && last && loop) ? '0 : ts_cnt + 1'b1;
        end
    end

    // Table write port (only while not busy) and registered read of the prefetch pointer
    always_ff @(posedge clk) begin
        if (ld_we && !busy) mem[ld_addr] <= {ld_ts, ld_flags, ld_lct};
        rd_data <= mem[rd_ptr_d];
    end

`ifdef EVSEQ_STATS_EN
    // Saturating counts of fired L1As and dropped late events, cleared on an accepted start
    always_ff @(posedge clk) begin
        if (!rst_n || go) begin
            l1a_cnt  <= '0;
            late_cnt <= '0;
        end else begin
            if (hit && cur[NLCT+2] && l1a_cnt != 16'hFFFF) l1a_cnt <= l1a_cnt + 1'b1;
            if (late && late_cnt != 16'hFFFF) late_cnt <= late_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_event_sequencer.sv
// tb_event_sequencer: directed and randomized replays checked against an event-list reference model.
module tb_event_sequencer;
    localparam int NLCT  = 8;
    localparam int TS_W  = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int OW    = 3 + NLCT + TS_W + 3;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0, ld_we = 1'b0;
    logic [AW:0] num_ev = '0;
    logic [AW-1:0] ld_addr = '0;
    logic [TS_W-1:0] ld_ts = '0;
    logic [2:0] ld_flags = '0;
    logic [NLCT-1:0] ld_lct = '0;
    logic l1a, alct_dav, otmb_dav, busy, done, err_late;
    logic [NLCT-1:0] lct;
    logic [TS_W-1:0] ts_cnt;
`ifdef EVSEQ_STATS_EN
    logic [15:0] l1a_cnt, late_cnt;
`endif

    event_sequencer #(.NLCT(NLCT), .TS_W(TS_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop), .loop(loop),
        .num_ev(num_ev), .ld_we(ld_we), .ld_addr(ld_addr), .ld_ts(ld_ts),
        .ld_flags(ld_flags), .ld_lct(ld_lct), .l1a(l1a), .alct_dav(alct_dav),
        .otmb_dav(otmb_dav), .lct(lct), .ts_cnt(ts_cnt), .busy(busy), .done(done),
        .err_late(err_late)
`ifdef EVSEQ_STATS_EN
        , .l1a_cnt(l1a_cnt), .late_cnt(late_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [TS_W-1:0] tb_ts [DEPTH];
    logic [2:0] tb_fl [DEPTH];
    logic [NLCT-1:0] tb_lct [DEPTH];
    logic [TS_W-1:0] m_cnt = '0;
    int m_l1a = 0, m_late = 0;

    function automatic logic [OW-1:0] obs();
        return {l1a, alct_dav, otmb_dav, lct, ts_cnt, err_late, done, busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [OW-1:0] o, input logic [OW-1:0] x);
        tests++;
        assert (o === x) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, x);
        end
    endtask

    task automatic set_ev(input int i, input logic [TS_W-1:0] t, input logic [2:0] f, input logic [NLCT-1:0] l);
        tb_ts[i] = t;
        tb_fl[i] = f;
        tb_lct[i] = l;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            ld_we = 1'b1;
            ld_addr = i[AW-1:0];
            ld_ts = tb_ts[i];
            ld_flags = tb_fl[i];
            ld_lct = tb_lct[i];
            step();
        end
        ld_we = 1'b0;
    endtask

    task automatic chk_stats(input string tag);
`ifdef EVSEQ_STATS_EN
        chk({tag, " l1a_cnt"}, OW'(l1a_cnt), OW'(m_l1a));
        chk({tag, " late_cnt"}, OW'(late_cnt), OW'(m_late));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // Reference model: walk the event list one counter tick at a time; an event whose timestamp
    // equals the counter fires (visible one cycle later), an earlier one is dropped as late.
    task automatic replay(input string tag, input int n, input bit lp, input int en_pct,
                          input int pause_t, input int pause_len, input int stop_at,
                          input int rst_at, input bit wr_run);
        int k, j, paused;
        logic [TS_W-1:0] t;
        logic [2+NLCT:0] pay;
        bit lm, e, s, r, fin, cons;
        k = 0; j = 0; paused = 0; t = '0; pay = '0; lm = 0; fin = 0;
        num_ev = n[AW:0];
        loop = lp;
        en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        m_l1a = 0;
        m_late = 0;
        if (n == 0) begin
            chk({tag, " empty done"}, obs(), {{(3+NLCT){1'b0}}, m_cnt, 1'b0, 1'b1, 1'b0});
            step();
            chk({tag, " empty after"}, obs(), {{(3+NLCT){1'b0}}, m_cnt, 1'b0, 1'b0, 1'b0});
            return;
        end
        chk({tag, " pf0"}, obs(), {{(3+NLCT){1'b0}}, m_cnt, 1'b0, 1'b0, 1'b1});
        step();
        chk({tag, " pf1"}, obs(), {{(3+NLCT){1'b0}}, m_cnt, 1'b0, 1'b0, 1'b1});
        step();
        while (j < 400) begin
            chk($sformatf("%s run%0d", tag, j), obs(), {pay, t, lm, 1'b0, 1'b1});
            e = ($urandom_range(99) < en_pct);
            if (t == pause_t && paused < pause_len) begin
                e = 0;
                paused++;
            end
            s = (j == stop_at);
            r = (j == rst_at);
            en = e;
            stop = s;
            rst_n = !r;
            ld_we = wr_run;
            ld_addr = 1;
            ld_ts = $urandom;
            ld_flags = 3'($urandom);
            ld_lct = NLCT'($urandom);
            pay = '0;
            fin = 0;
            if (!s && !r && e) begin
                cons = (tb_ts[k] <= t);
                if (tb_ts[k] == t) begin
                    pay = {tb_fl[k], tb_lct[k]};
                    if (tb_fl[k][2]) m_l1a++;
                end else if (cons) begin
                    lm = 1;
                    m_late++;
                end
                t = (cons && k == n - 1 && lp) ? '0 : t + 1;
                fin = cons && k == n - 1 && !lp;
                if (cons) k = (k == n - 1) ? 0 : k + 1;
            end
            step();
            j++;
            en = 1'b1; stop = 1'b0; rst_n = 1'b1; ld_we = 1'b0;
            if (r) begin
                chk({tag, " reset"}, obs(), '0);
                m_cnt = '0;
                return;
            end
            if (s) begin
                chk({tag, " stop"}, obs(), {{(3+NLCT){1'b0}}, t, lm, 1'b0, 1'b0});
                chk_stats(tag);
                m_cnt = t;
                return;
            end
            if (fin) begin
                chk({tag, " fin"}, obs(), {pay, t, lm, 1'b0, 1'b0});
                step();
                chk({tag, " done"}, obs(), {{(3+NLCT){1'b0}}, t, lm, 1'b1, 1'b0});
                step();
                chk({tag, " idle"}, obs(), {{(3+NLCT){1'b0}}, t, lm, 1'b0, 1'b0});
                chk_stats(tag);
                m_cnt = t;
                return;
            end
        end
        tests++;
        fails++;
        $error("FAIL %s timeout: cycles %0d expected completion before 400", tag, j);
    endtask

    task automatic basic_table();
        set_ev(0, 5, 3'b100, 8'h00);
        set_ev(1, 6, 3'b001, 8'hA5);
        set_ev(2, 10, 3'b010, 8'h00);
    endtask

    initial begin
        int n, stop_at;
        bit lp;
        repeat (3) step();
        rst_n = 1'b1;
        chk("reset state", obs(), '0);
        basic_table();
        load(3);
        replay("basic", 3, 0, 100, -1, 0, -1, -1, 0);
        replay("pause", 3, 0, 100, 3, 4, -1, -1, 0);
        set_ev(0, 4, 3'b100, 8'h11);
        set_ev(1, 4, 3'b010, 8'h22);
        set_ev(2, 9, 3'b001, 8'h33);
        load(3);
        replay("late", 3, 0, 100, -1, 0, -1, -1, 0);
        set_ev(0, 0, 3'b100, 8'h00);
        set_ev(1, 2, 3'b100, 8'h00);
        load(2);
        replay("loop", 2, 1, 100, -1, 0, 9, -1, 0);
        basic_table();
        load(3);
        replay("rst", 3, 0, 100, -1, 0, -1, 7, 0);
        replay("after_rst", 3, 0, 100, -1, 0, -1, -1, 0);
        replay("empty", 0, 0, 100, -1, 0, -1, -1, 0);
        replay("wr_run", 3, 0, 100, -1, 0, -1, -1, 1);
        replay("readback", 3, 0, 100, -1, 0, -1, -1, 0);
        set_ev(0, 3, 3'b111, 8'h5A);
        load(1);
        replay("single_loop", 1, 1, 100, -1, 0, 12, -1, 0);
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++)
                set_ev(i, (i == 0) ? TS_W'($urandom_range(0, 4)) : tb_ts[i-1] + TS_W'($urandom_range(0, 3)),
                       3'($urandom), NLCT'($urandom));
            load(n);
            lp = 1'($urandom_range(0, 1));
            stop_at = lp ? $urandom_range(4, 40) : (($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1);
            replay($sformatf("rand%0d", it), n, lp, 75, -1, 0, stop_at, -1, 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/event_sequencer.md
Name: event_sequencer

Overview:
- Synthesizable, parametrised successor of the simulation event-injection stimulus.
- A host loads a table of timestamped trigger events into internal memory. On start, a free-running timestamp counter replays each event's L1A / ALCT_DAV / OTMB_DAV / LCT pattern at its timestamp.
- Sits upstream of the DCFEB/ALCT/OTMB trigger inputs as an on-board test-pulse source.
- Adds loop mode, late-event detection and configurable depth and widths.

Parameters:
- NLCT, 8, width of lct bus.
- TS_W, 32, timestamp and counter width.
- DEPTH, 256, event table entries (power of two).
- AW, 8, address width, equals log2(DEPTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  count/fire enable; low pauses the sequencer
- start  in  1  one-cycle pulse, begins replay
- stop  in  1  one-cycle pulse, aborts replay
- loop  in  1  replay the table continuously
- num_ev  in  AW+1  number of valid entries, 0..DEPTH
- ld_we  in  1  table write strobe
- ld_addr  in  AW  table write address
- ld_ts  in  TS_W  event timestamp
- ld_flags  in  3  {l1a, alct_dav, otmb_dav}
- ld_lct  in  NLCT  event lct pattern
- l1a  out  1  fired L1A
- alct_dav  out  1  fired ALCT data-available
- otmb_dav  out  1  fired OTMB data-available
- lct  out  NLCT  fired LCT pattern
- ts_cnt  out  TS_W  current timestamp
- busy  out  1  sequencer not idle/done
- done  out  1  one-cycle pulse at end of a non-loop replay
- err_late  out  1  sticky late-event flag

Behaviour:
- Reset (rst_n low at clk edge):
  - All outputs 0, state IDLE, pointers 0.
  - Table contents are not cleared.
  - Reset overrides every other input, including mid-run.
- Table writes:
  - Accepted only when busy=0; ld_we while busy is ignored.
  - Single-port write, plus an internal registered read with 1-cycle latency.
- States: IDLE, PF0, PF1, RUN, FIN.
- IDLE:
  - start with num_ev=0 → done pulses next cycle, remain IDLE.
  - start with num_ev>0 → PF0.
- PF0: read entry 0 into the cur register.
- PF1: read entry 1 into the nxt register (index mod num_ev).
- Entering RUN: ts_cnt=0.
- RUN, each cycle with en=1:
  - cur_ts==ts_cnt → fire: outputs take cur payload on the next cycle for exactly one cycle. cur←nxt; nxt←next table entry. Back-to-back consecutive timestamps fire on consecutive cycles.
  - cur_ts<ts_cnt → late: set err_late, drop the event (outputs stay 0), advance as for a fire.
  - Otherwise, and on all non-fire cycles, outputs are 0.
  - ts_cnt increments by 1, wrapping modulo 2^TS_W.
- RUN with en=0:
  - ts_cnt holds, nothing fires, outputs 0.
  - Pending match is evaluated when en returns.
- Last entry (index num_ev-1) consumed, fired or dropped:
  - loop=0 → FIN.
  - loop=1 → ts_cnt=0 on the next cycle; pointers wrap; cur/nxt already hold entries 0/1; stays RUN.
  - num_ev=1 with loop: cur and nxt both hold entry 0.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- stop in any busy state:
  - Next cycle IDLE, outputs 0, no done pulse.
  - err_late is retained.
- start while busy is ignored.
- err_late clears only on start accepted in IDLE, or on reset.
- Timestamps must be non-decreasing within the table. An entry whose ts equals the previous entry's ts is late by definition.

Optional Feature:
- Macro EVSEQ_STATS_EN.
- Defined: adds outputs l1a_cnt[15:0] and late_cnt[15:0].
  - l1a_cnt counts fired events with l1a=1.
  - late_cnt counts dropped events.
  - Both saturate at 16'hFFFF and clear on start in IDLE or on reset.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Load 3 entries {ts=5, l1a}, {ts=6, otmb_dav, lct=8'hA5}, {ts=10, alct_dav}; num_ev=3, loop=0; start → l1a high during counter cycle 6 only, otmb_dav and lct=A5 during cycle 7, alct_dav during cycle 11, done one cycle later, busy 0.
- Same table, en low for 4 cycles at ts_cnt=3 → every output shifted 4 cycles later; ts_cnt frozen at 3 throughout.
- Entries {ts=4}, {ts=4}, {ts=9} → first fires, second dropped with err_late=1 (late_cnt=1 if EVSEQ_STATS_EN), third fires at ts=9.
- loop=1, entries {ts=0, l1a}, {ts=2, l1a} → l1a pattern repeats with period 3; stop after 3 loops → outputs 0 next cycle, no done pulse; l1a_cnt=6 if EVSEQ_STATS_EN.
- rst_n low mid-RUN → all outputs 0 on the next cycle; start with the table unchanged replays identically; start with num_ev=0 → done pulses next cycle, no event fires.
- ld_we during RUN to entry 1 → write ignored; readback via a second replay shows the original data.
